g_3dbnc: RTL and testbench
==========================

# g_3dbnc

Three-channel input conditioner that sits directly upstream of the three-input active-low OR macro. It takes three raw, asynchronous, active-high signals, synchronises each into the clock domain and debounces it. It then drives registered, active-low outputs AN, BN and CN that connect straight to the OR macro's inputs. A one-cycle CHG strobe flags every debounced transition, so downstream logic can sample the combined result without polling.

## Interface
Parameters:
- DB_CYCLES, default 8: number of consecutive synchronised cycles a new input level must persist before the output follows it. Legal range is 2 to 2^CNT_W.
- CNT_W, default 4: width of each channel's debounce counter.

Ports:
- CLK  input  1  single clock. All state updates on the rising edge.
- CD  input  1  reset, synchronous and active-high. Clears all state on the next rising CLK edge.
- A  input  1  raw channel A, asynchronous, active-high.
- B  input  1  raw channel B, asynchronous, active-high.
- C  input  1  raw channel C, asynchronous, active-high.
- AN  output  1  debounced channel A, active-low, registered.
- BN  output  1  debounced channel B, active-low, registered.
- CN  output  1  debounced channel C, active-low, registered.
- CHG  output  1  one-cycle pulse, registered. High in the first cycle in which any of AN, BN or CN shows a new value.

## Operation
- The three channels are identical and fully independent. Per-channel state:
  - s1, s2: two-flop synchroniser.
  - q: stable level.
  - cnt: CNT_W-bit debounce counter.
- Per-channel output relation: AN = ~q_A, BN = ~q_B, CN = ~q_C, all taken directly from flops.
- Per-channel update on each CLK edge when CD=0:
  - s1 <= raw input; s2 <= s1.
  - If s2 == q: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: q <= s2 and cnt <= 0. This is the "flip" condition.
  - Else: cnt <= cnt+1.
- CHG <= OR of the three channel flip conditions.
  - Two or three channels flipping on the same edge produce a single one-cycle CHG pulse.
- Glitch rejection: any return of s2 to q before the count completes clears cnt. A pulse shorter than DB_CYCLES synchronised cycles therefore never reaches the output.
- Width rule: cnt never exceeds DB_CYCLES-1, so it cannot wrap. An elaboration-time check rejects DB_CYCLES > 2^CNT_W or DB_CYCLES < 2.

## Timing
- Reset values, one edge after CD=1:
  - s1 = s2 = q = 0 and cnt = 0.
  - AN = BN = CN = 1 (inactive).
  - CHG = 0.
- CD has priority over every other condition, including a flip in the same cycle.
- Latency for a raw level that is stable from before edge 0:
  - Edge 0 loads s1; edge 1 loads s2.
  - cnt reaches DB_CYCLES-1 at edge DB_CYCLES.
  - The output changes at edge DB_CYCLES+1, and CHG is high for the cycle following that edge.
  - With the defaults (DB_CYCLES=8), the output changes at edge 9.
- Deassert timing is symmetric: the same DB_CYCLES+1 edges apply.
- Reset mid-count discards the partial count. After CD falls, a raw input still held high re-qualifies from scratch and asserts at edge DB_CYCLES+1, where edge 0 is the first edge with CD=0.
- There is no combinational path from any input to any output.

## Structure
- Sub-module g_dbnc1 implements one channel (synchroniser, counter, q, flip strobe). It is instantiated three times.
- The top level adds the output inversion and the CHG register.
- The default constants DB_CYCLES and CNT_W, and the legality check, live in the shared macro-library constants file so that other debounced macros reuse them.
- The counter is a plain unsigned vector; no typedefs are needed.

## Test plan
- Reset state:
  - Stimulus: CD=1 for 2 cycles with A=B=C=1.
  - Required: AN=BN=CN=1 and CHG=0 throughout reset and at the first edge after release.
- Assert latency:
  - Stimulus: DB_CYCLES=8; A rises before edge 0 and is held.
  - Required: AN falls at edge 9; CHG=1 for exactly that one cycle; BN=CN=1 throughout.
- Glitch rejection:
  - Stimulus: B high for 7 cycles, then low.
  - Required: BN stays 1 and CHG stays 0.
  - Follow-up: B high for 8 cycles, then low. Required: BN=0 for 8 cycles, then returns to 1, with one CHG pulse per transition.
- Simultaneous flips:
  - Stimulus: A and C rise on the same cycle.
  - Required: AN and CN fall on the same edge, and CHG is a single one-cycle pulse.
- Reset mid-count:
  - Stimulus: C high; assert CD at edge 5 for one cycle; C stays high.
  - Required: CN=1 until edge 9 counted from the first edge after CD falls, then CN=0.
- Bouncy input:
  - Stimulus: A toggles every 3 cycles for 40 cycles, then is held high.
  - Required: AN does not change during the toggling, then falls 9 edges after the last toggle.

Source files
------------

// File: rtl/g_3dbnc_pkg.sv
// -----------------------------------------------------------------------------
// g_3dbnc_pkg
// Shared constants for the debounced macro-library cells.
//   DB_CYCLES_DEF : default number of consecutive synchronised cycles a new
//                   level must persist before a debounced output follows it.
//   CNT_W_DEF     : default width of a per-channel debounce counter.
//   db_cfg_legal  : elaboration-time legality check for a (DB_CYCLES, CNT_W)
//                   pair; the counter must be able to hold DB_CYCLES-1 and a
//                   one-cycle debounce would be no filtering at all.
// -----------------------------------------------------------------------------
package g_3dbnc_pkg;

    localparam int DB_CYCLES_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    // The count tops out at DB_CYCLES-1, so DB_CYCLES may equal 2^CNT_W.
    function automatic bit db_cfg_legal(input int db_cycles, input int cnt_w);
        bit ok;
        ok = 1'b1;
        if (db_cycles < 32'sd2) begin
            ok = 1'b0;
        end else if (cnt_w < 32'sd1) begin
            ok = 1'b0;
        end else if (cnt_w < 32'sd31) begin
            if (db_cycles > (32'sd1 << cnt_w)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage : g_3dbnc_pkg

// File: rtl/g_3dbnc_dbnc1.sv
// -----------------------------------------------------------------------------
// g_dbnc1
// One debounced channel: two-flop synchroniser, debounce counter and the
// stable level q. The flip strobe is high in the cycle whose closing edge
// will load a new value into q, so a parent can register it alongside q.
// Ports:
//   clk  : clock, all state on the rising edge
//   cd   : synchronous active-high clear, priority over everything
//   raw  : asynchronous active-high input
//   q    : debounced stable level (flop output)
//   flip : the coming edge updates q (decoded from flops only)
// -----------------------------------------------------------------------------
module g_dbnc1
    import g_3dbnc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic cd,
    input  logic raw,
    output logic q,
    output logic flip
);

    if (!db_cfg_legal(DB_CYCLES, CNT_W)) begin : g_cfg_bad
        $error("g_dbnc1: DB_CYCLES must lie in 2 .. 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             s1_r;
    logic             s2_r;
    logic             q_r;
    logic [CNT_W-1:0] cnt_r;

    logic             q_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             flip_s;

    // Debounce decision: agreement clears the count, a completed count flips q.
    always_comb begin
        q_nxt_s   = q_r;
        cnt_nxt_s = cnt_r;
        flip_s    = 1'b0;
        if (s2_r == q_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            q_nxt_s   = s2_r;
            cnt_nxt_s = CNT_ZERO;
            flip_s    = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, stable level and counter state.
    always_ff @(posedge clk) begin
        if (cd) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            q_r   <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else begin
            s1_r  <= raw;
            s2_r  <= s1_r;
            q_r   <= q_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign q    = q_r;
    assign flip = flip_s;

endmodule : g_dbnc1

// File: rtl/g_3dbnc.sv
// -----------------------------------------------------------------------------
// g_3dbnc
// Three-channel conditioner feeding the active-low three-input OR macro.
// Each raw input is synchronised and debounced independently; the stable
// levels leave inverted (active-low) straight from their flops, and CHG pulses
// for one cycle alongside any debounced transition.
// Ports:
//   CLK        : clock, rising edge
//   CD         : synchronous active-high clear
//   A, B, C    : raw asynchronous active-high inputs
//   AN, BN, CN : debounced active-low outputs
//   CHG        : one-cycle pulse in the first cycle an output shows a new value
// -----------------------------------------------------------------------------
module g_3dbnc
    import g_3dbnc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic CLK,
    input  logic CD,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic AN,
    output logic BN,
    output logic CN,
    output logic CHG
);

    logic q_a_s;
    logic q_b_s;
    logic q_c_s;
    logic flip_a_s;
    logic flip_b_s;
    logic flip_c_s;
    logic chg_r;

    g_dbnc1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_a (
        .clk  (CLK),
        .cd   (CD),
        .raw  (A),
        .q    (q_a_s),
        .flip (flip_a_s)
    );

    g_dbnc1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_b (
        .clk  (CLK),
        .cd   (CD),
        .raw  (B),
        .q    (q_b_s),
        .flip (flip_b_s)
    );

    g_dbnc1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_c (
        .clk  (CLK),
        .cd   (CD),
        .raw  (C),
        .q    (q_c_s),
        .flip (flip_c_s)
    );

    // CHG is loaded on the same edge as the flipping q, so simultaneous flips merge into one pulse.
    always_ff @(posedge CLK) begin
        if (CD) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= flip_a_s | flip_b_s | flip_c_s;
        end
    end

    // Inversion is the only logic between the q flops and the pins.
    assign AN  = ~q_a_s;
    assign BN  = ~q_b_s;
    assign CN  = ~q_c_s;
    assign CHG = chg_r;

endmodule : g_3dbnc

// File: tb/tb_g_3dbnc.sv
// -----------------------------------------------------------------------------
// tb_g_3dbnc
// Directed bench for g_3dbnc with default parameters (DB_CYCLES=8).
// Inputs change 1 time unit after a rising edge; "edge i" is the i-th rising
// edge after the stimulus for step 0 was applied, and outputs are sampled
// 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_g_3dbnc;

    logic CLK = 1'b0;
    logic CD  = 1'b1;
    logic A   = 1'b0;
    logic B   = 1'b0;
    logic C   = 1'b0;
    logic AN;
    logic BN;
    logic CN;
    logic CHG;

    int n_total = 0;
    int n_bad   = 0;

    g_3dbnc dut (
        .CLK (CLK),
        .CD  (CD),
        .A   (A),
        .B   (B),
        .C   (C),
        .AN  (AN),
        .BN  (BN),
        .CN  (CN),
        .CHG (CHG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tn, input int i,
                           input logic an_e, input logic bn_e,
                           input logic cn_e, input logic chg_e);
        chk($sformatf("%s_an_%0d", tn, i), AN, an_e);
        chk($sformatf("%s_bn_%0d", tn, i), BN, bn_e);
        chk($sformatf("%s_cn_%0d", tn, i), CN, cn_e);
        chk($sformatf("%s_chg_%0d", tn, i), CHG, chg_e);
    endtask

    task automatic do_reset();
        CD = 1'b1; A = 1'b0; B = 1'b0; C = 1'b0;
        step();
        step();
        CD = 1'b0;
    endtask

    initial begin
        // Reset state with all raw inputs high.
        CD = 1'b1; A = 1'b1; B = 1'b1; C = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all("rst", i, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        CD = 1'b0;
        step();
        chk_all("rst_rel", 0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Assert latency on A: output changes at edge 9.
        do_reset();
        A = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_all("lat", i, (i >= 9) ? 1'b0 : 1'b1, 1'b1, 1'b1, (i == 9) ? 1'b1 : 1'b0);
        end

        // Seven-cycle glitch on B is rejected.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            B = (i < 7) ? 1'b1 : 1'b0;
            step();
            chk_all("gl7", i, 1'b1, 1'b1, 1'b1, 1'b0);
        end

        // Eight-cycle pulse on B passes: low at edge 9, back high at edge 17.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            B = (i < 8) ? 1'b1 : 1'b0;
            step();
            chk_all("gl8", i, 1'b1, (i >= 9 && i < 17) ? 1'b0 : 1'b1, 1'b1,
                    (i == 9 || i == 17) ? 1'b1 : 1'b0);
        end

        // A and C rise together: one merged CHG pulse.
        do_reset();
        A = 1'b1; C = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_all("sim", i, (i >= 9) ? 1'b0 : 1'b1, 1'b1, (i >= 9) ? 1'b0 : 1'b1,
                    (i == 9) ? 1'b1 : 1'b0);
        end

        // CD on edge 5 discards C's partial count; edge 6 is the new edge 0.
        do_reset();
        C = 1'b1;
        for (int i = 0; i < 18; i++) begin
            CD = (i == 5) ? 1'b1 : 1'b0;
            step();
            chk_all("rmc", i, 1'b1, 1'b1, (i >= 15) ? 1'b0 : 1'b1, (i == 15) ? 1'b1 : 1'b0);
        end
        CD = 1'b0;

        // CD on the would-be flip edge wins over the flip.
        do_reset();
        A = 1'b1;
        for (int i = 0; i < 13; i++) begin
            CD = (i == 9) ? 1'b1 : 1'b0;
            step();
            chk_all("rpr", i, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        CD = 1'b0;

        // A bounces with period 6 for 40 steps; last toggle (to high) before edge 39.
        do_reset();
        for (int i = 0; i < 52; i++) begin
            A = (i >= 40) ? 1'b1 : (((i / 3) % 2) == 1) ? 1'b1 : 1'b0;
            step();
            chk_all("bnc", i, (i >= 48) ? 1'b0 : 1'b1, 1'b1, 1'b1, (i == 48) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_g_3dbnc
